snake_state_packer: RTL and testbench
=====================================

# snake_state_packer

Producer side of the 488-bit `snake_data` bus consumed by `vga_controller`. The game-logic writer updates a shadow copy of the game state through word and direction write ports. The block transfers the whole shadow to the live bus atomically at the start of vertical sync, so the display never samples a half-updated frame. It sits between the game/processor logic and `vga_controller`, in the `iVGA_CLK` domain.

## Interface
Parameters
- `MAX_LEN`, default 49: the largest body length the display walks; larger length writes are clamped to this value.
- `DIR_ENTRIES`, default 100: number of 2-bit direction entries in `snake_data[199:0]`.

Ports
- `iVGA_CLK`  in  1: the only clock; all logic updates on its rising edge.
- `iRST_n`  in  1: reset, synchronous and active-low.
- `iVS_n`  in  1: vertical sync from `video_sync_generator`, active-low.
- `iWE`  in  1: word write strobe.
- `iADDR`  in  4: word address.
- `iWDATA`  in  32: word write data.
- `iDIR_WE`  in  1: direction write strobe.
- `iDIR_IDX`  in  7: direction entry index.
- `iDIR`  in  2: direction code; 00 = up (-40), 01 = right (+1), 10 = down (+40), 11 = left (-1).
- `iFRAME_DONE`  in  1: one-cycle pulse; the writer declares the shadow consistent.
- `oREADY`  out  1: high when writes are accepted.
- `oSNAKE_DATA`  out  488: live game state driven to `vga_controller`.
- `oCOMMIT`  out  1: one-cycle pulse when `oSNAKE_DATA` has just been updated.
- `oFRAME_CNT`  out  16: number of commits since reset; wraps.
- `oDROP_CNT`  out  8: number of writes rejected while not ready; saturates at 255.

## Operation
Word map. `iADDR` selects one 32-bit field of the shadow:
- 0: `head1position` [231:200]
- 1: `head2position` [263:232]
- 2: `length1` [295:264]
- 3: `length2` [327:296]
- 4: `stage` [359:328]
- 5: `head1` dir index [391:360]
- 6: `head2` dir index [423:392]
- 7: reserved [455:424]; reads as zero and writes are ignored.
- 8: `heartsTimer` [487:456]
- 9–15: ignored.
- Writes to 9–15 are not counted as drops.

Field rules:
- Lengths: the stored value is min(`iWDATA`, `MAX_LEN`), compared unsigned.
- `stage`: stored as written. Values other than 0, 2 and 3 are legal and display as "no change".
- Direction write: entry `iDIR_IDX` is stored in shadow bits [2*idx+1 : 2*idx].
- Direction writes with `iDIR_IDX` ≥ `DIR_ENTRIES` are ignored and not counted as drops.
- `iWE` and `iDIR_WE` in the same cycle are both applied, since they touch disjoint fields.

State machine:
- IDLE: `oREADY` = 1 and writes update the shadow. On `iFRAME_DONE` go to PENDING. A write in the same cycle as `iFRAME_DONE` is applied before the state change.
- PENDING: `oREADY` = 0. Any `iWE` or valid `iDIR_WE` is discarded and increments `oDROP_CNT` by 1 per strobe, saturating. Two strobes in one cycle count as 2.
  - `iFRAME_DONE` while PENDING is ignored.
  - On a vsync falling edge (`vs_q` = 1 and `iVS_n` = 0, where `vs_q` is `iVS_n` registered): copy the entire shadow to `oSNAKE_DATA`, pulse `oCOMMIT`, increment `oFRAME_CNT`, and return to IDLE.
- A vsync edge seen in the same cycle that IDLE accepts `iFRAME_DONE` does not commit. The commit waits for the next falling edge.
- The shadow is never cleared by a commit. The writer updates only the fields that changed.

Reset (`iRST_n` = 0 at a rising edge):
- State goes to IDLE.
- Shadow, `oSNAKE_DATA`, `oFRAME_CNT` and `oDROP_CNT` all become 0. `stage` = 0 gives the display's start screen.
- `oCOMMIT` = 0, `oREADY` = 1 from the first cycle after reset is released.
- `vs_q` is set to 1.
- Reset while PENDING abandons the pending frame; no commit occurs.

## Timing
- A shadow write at edge t is visible in the shadow after t, and on `oSNAKE_DATA` only after a later commit.
- `iFRAME_DONE` sampled at edge t: `oREADY` is low from after t.
- Falling edge detected at edge t (`vs_q` = 1, `iVS_n` = 0 sampled): `oSNAKE_DATA`, `oFRAME_CNT` and `oCOMMIT` = 1 update at t. `oREADY` = 1 after t. `oCOMMIT` drops after t+1.
- Worst-case commit latency from `iFRAME_DONE` is one frame plus one cycle.
- `oSNAKE_DATA` changes only on commit cycles, which fall inside vertical sync, when `vga_controller` is not displaying pixels.

## Test plan
- **Reset**: hold `iRST_n` = 0 for 3 cycles → `oSNAKE_DATA` = 0, `oREADY` = 1, `oFRAME_CNT` = 0, `oDROP_CNT` = 0.
- **Basic commit**: write `stage` = 2, `head1position` = 425, `length1` = 3, `head1` = 10, and dirs 11–13 = 01. Pulse `iFRAME_DONE`; `oSNAKE_DATA` stays 0 until the `iVS_n` falling edge. Then [359:328] = 2, [231:200] = 425, bits [27:22] = 010101, `oCOMMIT` pulses once, `oFRAME_CNT` = 1.
- **Clamp and ignore**: write `length2` = 200 → committed value 49. `iDIR_IDX` = 100 → no change. `iADDR` = 7 with 0xFFFFFFFF → [455:424] = 0. `oDROP_CNT` stays 0.
- **Drop while pending**: after `iFRAME_DONE`, issue 3 `iWE` plus 1 `iDIR_WE` in the same cycle as one of them → `oDROP_CNT` = 4. The committed data excludes them.
- **Simultaneous events**: `iFRAME_DONE` in the same cycle as the vsync falling edge → no commit that frame; the commit occurs at the next falling edge. `iFRAME_DONE` together with `iWE` (`heartsTimer` = 50) → 50 is committed.
- **Reset mid-operation**: reset while PENDING → no `oCOMMIT` at the next edge, outputs 0. Then 300 drop strobes → `oDROP_CNT` saturates at 255.

Source files
------------

// File: rtl/snake_state_packer.sv
// snake_state_packer: shadow copy of the game state that the game logic
// writes, plus the live snake_data bus for vga_controller. The whole shadow
// moves to the live bus in a single cycle, at a vsync falling edge, and only
// after the writer has declared the frame consistent.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | writes accepted into the shadow; waiting for iFRAME_DONE
// PENDING | shadow frozen, writes dropped; waiting for a vsync falling edge
module snake_state_packer #(
  parameter int MAX_LEN     = 49,
  parameter int DIR_ENTRIES = 100
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         iVS_n,
  input  logic         iWE,
  input  logic [3:0]   iADDR,
  input  logic [31:0]  iWDATA,
  input  logic         iDIR_WE,
  input  logic [6:0]   iDIR_IDX,
  input  logic [1:0]   iDIR,
  input  logic         iFRAME_DONE,
  output logic         oREADY,
  output logic [487:0] oSNAKE_DATA,
  output logic         oCOMMIT,
  output logic [15:0]  oFRAME_CNT,
  output logic [7:0]   oDROP_CNT
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

  state_t         state_q, state_d;
  logic [487:0]   shadow_q, shadow_d;
  logic [487:0]   data_q, data_d;
  logic           commit_q, commit_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic           vs_q, vs_d;

  logic           vs_fall;
  logic           word_valid;
  logic           dir_valid;
  logic [1:0]     drop_inc;
  logic [8:0]     drop_sum;
  logic [31:0]    len_clamped;

  // Strobe qualification, length clamp and vsync edge detect.
  always_comb begin
    vs_fall     = vs_q & ~iVS_n;
    // Addresses 9..15 are outside the map, so writes there are neither stored nor counted.
    word_valid  = iWE & (iADDR <= 4'd8);
    dir_valid   = iDIR_WE & (int'(iDIR_IDX) < DIR_ENTRIES);
    drop_inc    = {1'b0, word_valid} + {1'b0, dir_valid};
    drop_sum    = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
    len_clamped = (iWDATA > MAX_LEN_W) ? MAX_LEN_W : iWDATA;
  end

  // Next-state, shadow update, commit and counters.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    commit_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    vs_d        = iVS_n;

    case (state_q)
      IDLE: begin
        if (iWE) begin
          case (iADDR)
            4'd0:    shadow_d[231:200] = iWDATA;
            4'd1:    shadow_d[263:232] = iWDATA;
            4'd2:    shadow_d[295:264] = len_clamped;
            4'd3:    shadow_d[327:296] = len_clamped;
            4'd4:    shadow_d[359:328] = iWDATA;
            4'd5:    shadow_d[391:360] = iWDATA;
            4'd6:    shadow_d[423:392] = iWDATA;
            4'd8:    shadow_d[487:456] = iWDATA;
            default: ;
          endcase
        end
        if (dir_valid) begin
          shadow_d[{iDIR_IDX, 1'b0} +: 2] = iDIR;
        end
        // A vsync edge this cycle is deliberately not acted on; the commit
        // waits for the next falling edge so the frame is fully settled.
        if (iFRAME_DONE) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (vs_fall) begin
          data_d      = shadow_q;
          commit_d    = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      data_q      <= '0;
      commit_q    <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      vs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      vs_q        <= vs_d;
    end
  end

  assign oREADY      = (state_q == IDLE);
  assign oSNAKE_DATA = data_q;
  assign oCOMMIT     = commit_q;
  assign oFRAME_CNT  = frame_cnt_q;
  assign oDROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_snake_state_packer.sv
// Bench for snake_state_packer: directed scenarios followed by a random
// phase, every cycle compared against a field-level model of the game state.
module tb_snake_state_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vs_n;
  logic         we;
  logic [3:0]   addr;
  logic [31:0]  wdata;
  logic         dwe;
  logic [6:0]   didx;
  logic [1:0]   dir;
  logic         fd;
  logic         ready;
  logic [487:0] sdata;
  logic         commit;
  logic [15:0]  frame_cnt;
  logic [7:0]   drop_cnt;

  snake_state_packer dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iVS_n      (vs_n),
    .iWE        (we),
    .iADDR      (addr),
    .iWDATA     (wdata),
    .iDIR_WE    (dwe),
    .iDIR_IDX   (didx),
    .iDIR       (dir),
    .iFRAME_DONE(fd),
    .oREADY     (ready),
    .oSNAKE_DATA(sdata),
    .oCOMMIT    (commit),
    .oFRAME_CNT (frame_cnt),
    .oDROP_CNT  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: named fields of the game state, shadow and live copies.
  logic [31:0] m_word [9];
  logic [1:0]  m_dir  [100];
  logic [31:0] l_word [9];
  logic [1:0]  l_dir  [100];
  bit          m_pending;
  bit          m_commit;
  bit          m_vs_prev;
  int          m_frames;
  int          m_drops;

  function automatic logic [487:0] pack_live();
    logic [487:0] v;
    v = '0;
    for (int i = 0; i < 100; i++) v[2*i +: 2] = l_dir[i];
    for (int i = 0; i < 7; i++) v[200 + 32*i +: 32] = l_word[i];
    v[487:456] = l_word[8];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [487:0] got, input logic [487:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_edge();
    bit fall;
    int n;
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin m_word[i] = 0; l_word[i] = 0; end
      for (int i = 0; i < 100; i++) begin m_dir[i] = 0; l_dir[i] = 0; end
      m_pending = 0; m_commit = 0; m_vs_prev = 1; m_frames = 0; m_drops = 0;
      return;
    end
    fall = m_vs_prev && !vs_n;
    m_commit = 0;
    if (!m_pending) begin
      if (we && addr <= 8 && addr != 7) begin
        if (addr == 2 || addr == 3) m_word[addr] = (wdata > 49) ? 32'd49 : wdata;
        else m_word[addr] = wdata;
      end
      if (dwe && didx < 100) m_dir[didx] = dir;
      if (fd) m_pending = 1;
    end else begin
      n = 0;
      if (we && addr <= 8) n++;
      if (dwe && didx < 100) n++;
      m_drops = (m_drops + n > 255) ? 255 : m_drops + n;
      if (fall) begin
        l_word = m_word;
        l_dir = m_dir;
        m_commit = 1;
        m_frames = (m_frames + 1) % 65536;
        m_pending = 0;
      end
    end
    m_vs_prev = vs_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready",  488'(ready),     488'(!m_pending));
    chk("commit", 488'(commit),    488'(m_commit));
    chk("frames", 488'(frame_cnt), 488'(m_frames[15:0]));
    chk("drops",  488'(drop_cnt),  488'(m_drops[7:0]));
    chk("data",   sdata,           pack_live());
    @(negedge clk);
  endtask

  task automatic quiet();
    we = 0; addr = 0; wdata = 0; dwe = 0; didx = 0; dir = 0; fd = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    quiet(); we = 1; addr = a; wdata = d; tick(); quiet();
  endtask

  task automatic dwr(input logic [6:0] i, input logic [1:0] d);
    quiet(); dwe = 1; didx = i; dir = d; tick(); quiet();
  endtask

  task automatic frame_done();
    quiet(); fd = 1; tick(); quiet();
  endtask

  task automatic vsync_pulse();
    vs_n = 1; tick(); tick();
    vs_n = 0; tick();
    vs_n = 0; tick();
    vs_n = 1; tick();
  endtask

  initial begin
    quiet();
    vs_n = 1;
    rst_n = 0;
    @(negedge clk);

    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_data", sdata, '0);
    chk("rst_ready", 488'(ready), 488'(1));
    rst_n = 1;
    tick();

    // Basic commit.
    wr(4, 2); wr(0, 425); wr(2, 3); wr(5, 10);
    dwr(11, 1); dwr(12, 1); dwr(13, 1);
    frame_done();
    tick(); tick();
    chk("pre_commit_data", sdata, '0);
    vsync_pulse();
    chk("stage", 488'(sdata[359:328]), 488'(2));
    chk("head1pos", 488'(sdata[231:200]), 488'(425));
    chk("dirs", 488'(sdata[27:22]), 488'(6'b010101));
    chk("frame1", 488'(frame_cnt), 488'(1));

    // Clamp and ignore.
    wr(3, 200);
    dwr(100, 3);
    wr(7, 32'hFFFF_FFFF);
    wr(9, 32'h1234);
    frame_done();
    vsync_pulse();
    chk("len2_clamp", 488'(sdata[327:296]), 488'(49));
    chk("reserved", 488'(sdata[455:424]), 488'(0));
    chk("no_drops", 488'(drop_cnt), 488'(0));

    // Drops while pending.
    frame_done();
    wr(0, 999); wr(1, 777);
    quiet(); we = 1; addr = 8; wdata = 5; dwe = 1; didx = 0; dir = 3; tick(); quiet();
    vsync_pulse();
    chk("drop4", 488'(drop_cnt), 488'(4));
    chk("drop_excluded", 488'(sdata[231:200]), 488'(425));

    // Frame done coincident with a vsync falling edge.
    vs_n = 1; tick();
    quiet(); fd = 1; vs_n = 0; tick(); quiet();
    chk("no_commit_same_edge", 488'(commit), 488'(0));
    tick();
    vs_n = 1; tick();
    vs_n = 0; tick();
    chk("late_commit", 488'(commit), 488'(1));
    vs_n = 1; tick();

    // Frame done together with a write.
    quiet(); fd = 1; we = 1; addr = 8; wdata = 50; tick(); quiet();
    vsync_pulse();
    chk("hearts", 488'(sdata[487:456]), 488'(50));

    // Random phase.
    for (int c = 0; c < 600; c++) begin
      quiet();
      vs_n = ((c % 23) >= 20) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        we = 1;
        addr = m_pending ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
        wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 100));
      end
      if ($urandom_range(0, 2) == 0) begin
        dwe = 1; didx = 7'($urandom_range(0, 127)); dir = 2'($urandom);
      end
      fd = ($urandom_range(0, 9) == 0);
      tick();
    end
    quiet();

    // Reset while pending: no commit, everything cleared.
    vs_n = 1; tick();
    frame_done();
    rst_n = 0; vs_n = 0; tick();
    chk("rst_no_commit", 488'(commit), 488'(0));
    chk("rst_cleared", sdata, '0);
    rst_n = 1; vs_n = 0; tick();
    chk("rst_no_commit2", 488'(commit), 488'(0));

    // Saturation of the drop counter.
    vs_n = 1; tick();
    frame_done();
    for (int i = 0; i < 300; i++) begin
      quiet(); we = 1; addr = 4'(i % 9); wdata = 32'(i); tick();
    end
    quiet();
    chk("drop_sat", 488'(drop_cnt), 488'(255));
    vsync_pulse();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
